// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI multiplier command sequencer.
package spi_ctrl_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_ILLEGAL = 4;

    typedef enum logic [3:0] {
        OPC_NONE    = 4'd0,
        OPC_WR_A    = 4'd1,
        OPC_WR_B    = 4'd2,
        OPC_START   = 4'd3,
        OPC_RD_LO   = 4'd4,
        OPC_RD_HI   = 4'd5,
        OPC_RD_STAT = 4'd6,
        OPC_CLR_ERR = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_EXEC = 2'd2,
        S_BUSY = 2'd3
    } state_e;

    function automatic logic [15:0] pack_status(
        input logic busy,
        input logic done,
        input logic err,
        input logic timeout,
        input logic illegal
    );
        logic [15:0] s;
        s               = 16'h0000;
        s[STAT_BUSY]    = busy;
        s[STAT_DONE]    = done;
        s[STAT_ERR]     = err;
        s[STAT_TIMEOUT] = timeout;
        s[STAT_ILLEGAL] = illegal;
        return s;
    endfunction

endpackage

// File: rtl/spi_ctrl_timeout.sv
// Multiply watchdog: counts enabled cycles and flags when TIMEOUT_CYCLES is reached.
module spi_ctrl_timeout
    import spi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_r;

    assign expired = (cnt_r == CNT_W'(TIMEOUT_CYCLES));

    // Cycle counter; holds once expired so it can never wrap back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/spi_mult_ctrl.sv
// SPI command sequencer for the 16x16 multiplier.
// Optional SPI_CTRL_AUTOSTART_EN: a completed WR_B data frame implies START.
module spi_mult_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_rx_valid,
    input  logic [DATA_WIDTH-1:0]   spi_rx_data,
    input  logic                    spi_tx_done,
    output logic                    spi_start,
    output logic [DATA_WIDTH-1:0]   spi_tx_data,
    output logic [DATA_WIDTH-1:0]   mult_a,
    output logic [DATA_WIDTH-1:0]   mult_b,
    output logic                    mult_start,
    input  logic                    mult_done,
    input  logic [2*DATA_WIDTH-1:0] mult_result,
    output logic                    busy,
    output logic                    err
);

    state_e                  state_r;
    logic [3:0]              opcode_r;
    logic [2*DATA_WIDTH-1:0] result_r;
    logic                    done_r;
    logic                    timeout_r;
    logic                    illegal_r;

    logic [3:0]              rx_opc_s;
    logic [DATA_WIDTH-1:0]   status_s;
    logic                    tmr_clr_s;
    logic                    tmr_en_s;
    logic                    expired_s;
    logic                    unused_tx_done_s;

    assign rx_opc_s  = spi_rx_data[OPC_MSB:OPC_LSB];
    assign status_s  = DATA_WIDTH'(pack_status(busy, done_r, err, timeout_r, illegal_r));
    assign tmr_clr_s = (state_r == S_EXEC);
    assign tmr_en_s  = (state_r == S_BUSY);
    // The end of a MISO frame carries no state; the read value simply stays loaded.
    assign unused_tx_done_s = spi_tx_done;

    spi_ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (expired_s)
    );

    // Command FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            opcode_r    <= 4'd0;
            result_r    <= {(2*DATA_WIDTH){1'b0}};
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            illegal_r   <= 1'b0;
            spi_start   <= 1'b0;
            spi_tx_data <= {DATA_WIDTH{1'b0}};
            mult_a      <= {DATA_WIDTH{1'b0}};
            mult_b      <= {DATA_WIDTH{1'b0}};
            mult_start  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            spi_start  <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    if (spi_rx_valid) begin
                        opcode_r <= rx_opc_s;
                        case (rx_opc_s)
                            OPC_WR_A, OPC_WR_B: state_r <= S_DATA;
                            default: begin
                                state_r   <= S_EXEC;
                                spi_start <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (spi_rx_valid) begin
                        if (opcode_r == OPC_WR_A) begin
                            mult_a <= spi_rx_data;
                        end else begin
                            mult_b <= spi_rx_data;
                        end
`ifdef SPI_CTRL_AUTOSTART_EN
                        if (opcode_r == OPC_WR_B) begin
                            opcode_r  <= OPC_START;
                            state_r   <= S_EXEC;
                            spi_start <= 1'b0;
                        end else begin
                            state_r <= S_IDLE;
                        end
`else
                        state_r <= S_IDLE;
`endif
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_EXEC: begin
                    state_r <= S_IDLE;
                    case (opcode_r)
                        OPC_START: begin
                            mult_start <= 1'b1;
                            busy       <= 1'b1;
                            done_r     <= 1'b0;
                            state_r    <= S_BUSY;
                        end
                        OPC_RD_LO:   spi_tx_data <= result_r[DATA_WIDTH-1:0];
                        OPC_RD_HI:   spi_tx_data <= result_r[2*DATA_WIDTH-1:DATA_WIDTH];
                        OPC_RD_STAT: spi_tx_data <= status_s;
                        OPC_CLR_ERR: begin
                            err       <= 1'b0;
                            timeout_r <= 1'b0;
                            illegal_r <= 1'b0;
                        end
                        OPC_WR_A, OPC_WR_B: state_r <= S_IDLE;
                        default: begin
                            err       <= 1'b1;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_BUSY: begin
                    // Only status polling is legal while the multiplier runs.
                    if (spi_rx_valid) begin
                        if (rx_opc_s == OPC_RD_STAT) begin
                            spi_tx_data <= status_s;
                        end else begin
                            err       <= 1'b1;
                            illegal_r <= 1'b1;
                        end
                    end
                    if (mult_done) begin
                        result_r <= mult_result;
                        done_r   <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end else if (expired_s) begin
                        timeout_r <= 1'b1;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_BUSY;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mult_ctrl.sv
// Self-checking bench for spi_mult_ctrl with a behavioural multiplier and read scoreboard.
module tb_spi_mult_ctrl;

`ifdef SPI_CTRL_AUTOSTART_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_rx_valid = 1'b0;
    logic [15:0] spi_rx_data = 16'h0000;
    logic        spi_tx_done = 1'b0;
    logic        mult_done = 1'b0;
    logic [31:0] mult_result = 32'h0;
    logic        spi_start;
    logic [15:0] spi_tx_data;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic        mult_start;
    logic        busy;
    logic        err;

    int          nchecks = 0;
    int          nerrs = 0;
    int          model_delay = 0;
    int          lat = 0;
    logic [31:0] model_prod;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[3];

    spi_mult_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_done  (spi_tx_done),
        .spi_start    (spi_start),
        .spi_tx_data  (spi_tx_data),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .mult_result  (mult_result),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: answers a start pulse after model_delay cycles (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (mult_start === 1'b1 && model_delay > 0) begin
                model_prod = 32'(mult_a) * 32'(mult_b);
                repeat (model_delay - 1) @(negedge clk);
                mult_done   = 1'b1;
                mult_result = model_prod;
                @(negedge clk);
                mult_done   = 1'b0;
                mult_result = 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerrs);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] f);
        @(negedge clk);
        spi_rx_valid = 1'b1;
        spi_rx_data  = f;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        spi_rx_data  = 16'h0000;
    endtask

    task automatic do_read(input logic [15:0] cmd, input logic [15:0] exp, input string name);
        exp_q.push_back(exp);
        send(cmd);
        repeat (2) @(negedge clk);
        check(name, 32'(spi_tx_data), 32'(exp_q.pop_front()));
        spi_tx_done = 1'b1;
        @(negedge clk);
        spi_tx_done = 1'b0;
    endtask

    task automatic wait_busy_low(input int max, output int n);
        n = 0;
        while (busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", 32'(busy), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_spi_start"}, 32'(spi_start), 32'(0));
        check({tag, "_tx_data"}, 32'(spi_tx_data), 32'(0));
        check({tag, "_mult_a"}, 32'(mult_a), 32'(0));
        check({tag, "_mult_b"}, 32'(mult_b), 32'(0));
        check({tag, "_mult_start"}, 32'(mult_start), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
    endtask

    initial begin
        tbl[0] = '{cmd: 16'h4000, exp: 16'h000F};
        tbl[1] = '{cmd: 16'h5000, exp: 16'h0000};
        tbl[2] = '{cmd: 16'h6000, exp: 16'h0002};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check("idle_spi_start", 32'(spi_start), 32'(1));

        // Basic multiply 3 * 5
        model_delay = 10;
        send(16'h1000);
        send(16'h0003);
        check("wr_a", 32'(mult_a), 32'h3);
        send(16'h2000);
        send(16'h0005);
        @(negedge clk);
        check("wrb_autostart", 32'(mult_start), 32'(AUTO));
        check("wr_b", 32'(mult_b), 32'h5);
`ifndef SPI_CTRL_AUTOSTART_EN
        send(16'h3000);
        @(negedge clk);
        check("start_pulse", 32'(mult_start), 32'(1));
`endif
        check("busy_set", 32'(busy), 32'(1));
        @(negedge clk);
        check("start_one_cycle", 32'(mult_start), 32'(0));
        wait_busy_low(100, lat);
        for (int i = 0; i < 3; i++) begin
            do_read(tbl[i].cmd, tbl[i].exp, $sformatf("tbl_rd%0d", i));
        end

        // Timeout: multiplier never answers
        model_delay = 0;
        send(16'h3000);
        @(negedge clk);
        check("to_busy", 32'(busy), 32'(1));
        wait_busy_low(200, lat);
        check("to_latency", 32'(lat >= 64 && lat <= 66), 32'(1));
        check("to_err", 32'(err), 32'(1));
        do_read(16'h6000, 16'h000C, "to_stat");
        send(16'h7000);
        repeat (2) @(negedge clk);
        check("clr_err", 32'(err), 32'(0));
        check("tx_hold", 32'(spi_tx_data), 32'h000C);
        do_read(16'h6000, 16'h0000, "clr_stat");

        // Illegal opcode
        send(16'hF000);
        repeat (2) @(negedge clk);
        check("ill_err", 32'(err), 32'(1));
        check("ill_idle", 32'(spi_start), 32'(1));
        do_read(16'h6000, 16'h0014, "ill_stat");
        check("ill_a", 32'(mult_a), 32'h3);
        check("ill_b", 32'(mult_b), 32'h5);
        send(16'h7000);

        // Commands while busy
        model_delay = 20;
        send(16'h3000);
        @(negedge clk);
        check("bz_busy", 32'(busy), 32'(1));
        do_read(16'h6000, 16'h0001, "bz_stat");
        check("bz_still_busy", 32'(busy), 32'(1));
        send(16'h1000);
        repeat (2) @(negedge clk);
        check("bz_err", 32'(err), 32'(1));
        check("bz_a_kept", 32'(mult_a), 32'h3);
        wait_busy_low(100, lat);
        do_read(16'h6000, 16'h0016, "bz_done_stat");
        do_read(16'h4000, 16'h000F, "bz_lo");
        send(16'h7000);

        // Reset during a pending multiply
        model_delay = 10;
        send(16'h3000);
        repeat (3) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        do_read(16'h6000, 16'h0000, "rst_stat");
        do_read(16'h4000, 16'h0000, "rst_lo");

        // WR_B 7 (implied START when autostart is built in)
        model_delay = 10;
        send(16'h1000);
        send(16'h0003);
        send(16'h2000);
        send(16'h0007);
        @(negedge clk);
        check("as_pulse", 32'(mult_start), 32'(AUTO));
        check("as_b", 32'(mult_b), 32'h7);
`ifndef SPI_CTRL_AUTOSTART_EN
        send(16'h3000);
`endif
        @(negedge clk);
        check("as_busy", 32'(busy), 32'(1));
        wait_busy_low(100, lat);
        do_read(16'h4000, 16'h0015, "as_lo");

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
